// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - two-entry skid-buffer pipeline stage register with flush
module pipe_stage_skid #(
  parameter int DATA_W            = 32,
  parameter int CTRL_W            = 8,
  parameter bit CLR_DATA_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              in_ready_q;
  logic              out_valid_q;

  logic in_xfer;
  logic out_xfer;

  // Handshakes are qualified by the registered flags only, so ready never depends on out_ready.
  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  // All outputs come straight from registers.
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign occupancy = state;

  // Stage state machine; main always holds the oldest entry, skid the younger one.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state       <= EMPTY;
      main_data   <= '0;
      main_ctrl   <= '0;
      skid_data   <= '0;
      skid_ctrl   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      // Flush wins over an incoming entry; the head may still be consumed this edge.
      state       <= EMPTY;
      main_ctrl   <= '0;
      skid_ctrl   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      if (CLR_DATA_ON_FLUSH) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      case (state)
        EMPTY: begin
          // First edge after reset release only raises in_ready.
          in_ready_q <= 1'b1;
          if (in_xfer) begin
            main_data   <= in_data;
            main_ctrl   <= in_ctrl;
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
          end else if (in_xfer) begin
            skid_data  <= in_data;
            skid_ctrl  <= in_ctrl;
            in_ready_q <= 1'b0;
            state      <= TWO;
          end else if (out_xfer) begin
            // Bubble: control reads zero so downstream sees a NOP.
            main_ctrl   <= '0;
            out_valid_q <= 1'b0;
            state       <= EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            main_data  <= skid_data;
            main_ctrl  <= skid_ctrl;
            skid_ctrl  <= '0;
            in_ready_q <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state       <= EMPTY;
          main_ctrl   <= '0;
          skid_ctrl   <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard testbench for pipe_stage_skid
module tb_pipe_stage_skid;

  logic        clk = 1'b1;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [7:0]  a_out_ctrl;
  logic [1:0]  a_occ;

  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [7:0]  b_out_ctrl;
  logic [1:0]  b_occ;

  logic        c_in_valid = 1'b0;
  logic [63:0] c_in_data = '0;
  logic [11:0] c_in_ctrl = '0;
  logic        c_out_ready = 1'b0;
  logic        c_in_ready, c_out_valid;
  logic [63:0] c_out_data;
  logic [11:0] c_out_ctrl;
  logic [1:0]  c_occ;

  int checks = 0;
  int passed = 0;
  int c_pops = 0;
  logic [39:0] q_a[$];
  logic [75:0] q_c[$];

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .CLR_DATA_ON_FLUSH(1'b1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
    .occupancy(a_occ)
  );

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .CLR_DATA_ON_FLUSH(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .occupancy(b_occ)
  );

  pipe_stage_skid #(.DATA_W(64), .CTRL_W(12), .CLR_DATA_ON_FLUSH(1'b1)) dut_c (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_ctrl(c_in_ctrl),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .out_ctrl(c_out_ctrl),
    .occupancy(c_occ)
  );

  // Scoreboard for dut_a: sampled mid-cycle, ahead of the falling edge that transfers.
  always @(posedge clk) begin
    if (reset) begin
      if (a_out_valid && out_ready) begin
        checks++;
        if (q_a.size() == 0) begin
          $display("FAIL sb_a_unexpected: got %h want nothing", {a_out_data, a_out_ctrl});
        end else begin
          logic [39:0] exp_a;
          exp_a = q_a.pop_front();
          if ({a_out_data, a_out_ctrl} !== exp_a)
            $display("FAIL sb_a_order: got %h want %h", {a_out_data, a_out_ctrl}, exp_a);
          else
            passed++;
        end
      end
      if (!a_out_valid) begin
        checks++;
        if (a_out_ctrl !== 8'h00) $display("FAIL a_bubble_ctrl: got %h want 00", a_out_ctrl);
        else passed++;
      end
      if (flush) q_a.delete();
      else if (in_valid && a_in_ready) q_a.push_back({in_data, in_ctrl});
    end
  end

  // Scoreboard for dut_c (wide legacy-stall instance).
  always @(posedge clk) begin
    if (reset) begin
      if (c_out_valid && c_out_ready) begin
        checks++;
        c_pops++;
        if (q_c.size() == 0) begin
          $display("FAIL sb_c_unexpected: got %h want nothing", {c_out_data, c_out_ctrl});
        end else begin
          logic [75:0] exp_c;
          exp_c = q_c.pop_front();
          if ({c_out_data, c_out_ctrl} !== exp_c)
            $display("FAIL sb_c_order: got %h want %h", {c_out_data, c_out_ctrl}, exp_c);
          else
            passed++;
        end
      end
      if (!c_out_valid) begin
        checks++;
        if (c_out_ctrl !== 12'h000) $display("FAIL c_bubble_ctrl: got %h want 000", c_out_ctrl);
        else passed++;
      end
      if (flush) q_c.delete();
      else if (c_in_valid && c_in_ready) q_c.push_back({c_in_data, c_in_ctrl});
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [37:0] exp;
    reset = 1'b0;
    repeat (3) tick();
    exp = '0;
    checks++;
    if ({a_occ, a_in_ready, a_out_valid, a_out_data, a_out_ctrl} !== exp[37:0] + 38'd0 ||
        {b_occ, b_in_ready, b_out_valid} !== 4'b0000)
      $display("FAIL reset_state: got %h want %h", {a_occ, a_in_ready, a_out_valid, a_out_data, a_out_ctrl}, 44'h0);
    else passed++;
    reset = 1'b1;
    #2;
    checks++;
    if (a_in_ready !== 1'b0) $display("FAIL reset_ready_early: got %b want 0", a_in_ready);
    else passed++;
    tick();
    checks++;
    if ({a_occ, a_in_ready, a_out_valid} !== 4'b0010)
      $display("FAIL reset_release: got %b want 0010", {a_occ, a_in_ready, a_out_valid});
    else passed++;
  endtask

  task automatic test_stream();
    logic [35:0] exp;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h10 + 32'(i);
      in_ctrl = 8'h80 | 8'(i);
      tick();
      exp = {2'd1, 1'b1, 1'b1, 32'h10 + 32'(i)};
      checks++;
      if ({a_occ, a_in_ready, a_out_valid, a_out_data} !== exp)
        $display("FAIL stream_%0d: got %h want %h", i, {a_occ, a_in_ready, a_out_valid, a_out_data}, exp);
      else passed++;
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if ({a_occ, a_in_ready, a_out_valid, a_out_ctrl} !== {2'd0, 1'b1, 1'b0, 8'h00})
      $display("FAIL stream_drain: got %h want %h", {a_occ, a_in_ready, a_out_valid, a_out_ctrl}, {2'd0, 1'b1, 1'b0, 8'h00});
    else passed++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAAAA_0000;
    in_ctrl   = 8'hA1;
    tick();
    checks++;
    if ({a_occ, a_in_ready, a_out_data} !== {2'd1, 1'b1, 32'hAAAA_0000})
      $display("FAIL bp_first: got %h want %h", {a_occ, a_in_ready, a_out_data}, {2'd1, 1'b1, 32'hAAAA_0000});
    else passed++;
    in_data = 32'hBBBB_0000;
    in_ctrl = 8'hB2;
    tick();
    checks++;
    if ({a_occ, a_in_ready, a_out_data, a_out_ctrl} !== {2'd2, 1'b0, 32'hAAAA_0000, 8'hA1})
      $display("FAIL bp_full: got %h want %h", {a_occ, a_in_ready, a_out_data, a_out_ctrl}, {2'd2, 1'b0, 32'hAAAA_0000, 8'hA1});
    else passed++;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if ({a_occ, a_in_ready, a_out_valid, a_out_data, a_out_ctrl} !== {2'd1, 1'b1, 1'b1, 32'hBBBB_0000, 8'hB2})
      $display("FAIL bp_drain1: got %h want %h", {a_occ, a_in_ready, a_out_valid, a_out_data, a_out_ctrl}, {2'd1, 1'b1, 1'b1, 32'hBBBB_0000, 8'hB2});
    else passed++;
    tick();
    checks++;
    if ({a_occ, a_in_ready, a_out_valid} !== {2'd0, 1'b1, 1'b0})
      $display("FAIL bp_drain2: got %b want 0010", {a_occ, a_in_ready, a_out_valid});
    else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1234_5678;
    in_ctrl   = 8'hC1;
    tick();
    in_data = 32'h9ABC_DEF0;
    in_ctrl = 8'hC2;
    tick();
    checks++;
    if ({a_occ, b_occ} !== 4'b1010) $display("FAIL flush_fill: got %b want 1010", {a_occ, b_occ});
    else passed++;
    flush   = 1'b1;
    in_data = 32'hDEAD_BEEF;
    in_ctrl = 8'hEE;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({a_occ, a_in_ready, a_out_valid, a_out_ctrl, a_out_data} !== {2'd0, 1'b1, 1'b0, 8'h00, 32'h0})
      $display("FAIL flush_clr: got %h want %h", {a_occ, a_in_ready, a_out_valid, a_out_ctrl, a_out_data}, {2'd0, 1'b1, 1'b0, 8'h00, 32'h0});
    else passed++;
    checks++;
    if ({b_occ, b_in_ready, b_out_valid, b_out_ctrl, b_out_data} !== {2'd0, 1'b1, 1'b0, 8'h00, 32'h1234_5678})
      $display("FAIL flush_keep: got %h want %h", {b_occ, b_in_ready, b_out_valid, b_out_ctrl, b_out_data}, {2'd0, 1'b1, 1'b0, 8'h00, 32'h1234_5678});
    else passed++;
    out_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if ({a_out_valid, b_out_valid, a_occ} !== 4'b0000)
      $display("FAIL flush_dropped: got %b want 0000", {a_out_valid, b_out_valid, a_occ});
    else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_5555;
    in_ctrl   = 8'h55;
    tick();
    in_data = 32'h0000_6666;
    in_ctrl = 8'h66;
    tick();
    in_valid = 1'b0;
    checks++;
    if (a_occ !== 2'd2) $display("FAIL areset_fill: got %0d want 2", a_occ);
    else passed++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    q_a.delete();
    checks++;
    if ({a_occ, a_in_ready, a_out_valid, a_out_data, a_out_ctrl, b_occ, b_out_data} !== 78'h0)
      $display("FAIL areset_now: got %h want 0", {a_occ, a_in_ready, a_out_valid, a_out_data, a_out_ctrl, b_occ, b_out_data});
    else passed++;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({a_occ, a_in_ready, a_out_valid} !== 4'b0010)
      $display("FAIL areset_release: got %b want 0010", {a_occ, a_in_ready, a_out_valid});
    else passed++;
  endtask

  task automatic test_legacy_stall();
    logic [3:0]  pattern;
    logic [63:0] n;
    logic        accepted;
    pattern    = 4'b1001;
    n          = 64'h1_0000_0000;
    c_in_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      c_out_ready = pattern[3 - (i % 4)];
      c_in_data   = n;
      c_in_ctrl   = 12'h800 | 12'(n[10:0]);
      accepted    = c_in_ready;
      tick();
      if (accepted) n = n + 64'd1;
    end
    c_in_valid  = 1'b0;
    c_out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({c_occ, c_out_valid} !== 3'b000 || q_c.size() != 0)
      $display("FAIL legacy_drain: got occ %0d left %0d want 0 0", c_occ, q_c.size());
    else passed++;
    checks++;
    if (c_pops != int'(n - 64'h1_0000_0000) || c_pops < 12)
      $display("FAIL legacy_count: got %0d want %0d", c_pops, int'(n - 64'h1_0000_0000));
    else passed++;
    c_out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_legacy_stall();
    checks++;
    if (q_a.size() != 0) $display("FAIL sb_a_leftover: got %0d want 0", q_a.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline-stage register that replaces the fixed stall-only inter-stage registers with a two-entry skid buffer.
- Uses a valid/ready handshake on both sides, so back-pressure does not need a combinational ready path through the stage.
- Adds a synchronous flush that inserts bubbles.
- Instantiated between any two pipeline stages of the RISC-V core (ID/EX, EX/MEM, MEM/WB) with stage-specific data and control widths.

Parameters:
- DATA_W, 32, width of the datapath payload (ALU result, store data, pc+4, etc. concatenated by the instantiator).
- CTRL_W, 8, width of the control payload (reg_write, mem_read, mem_write, branch, rd, ...). Cleared to zero on flush or bubble.
- CLR_DATA_ON_FLUSH, 1, when 1 a flush also zeroes the data payload; when 0 data is left unchanged.

Ports:
- clk, input, 1, stage clock. All state updates on the falling edge.
- reset, input, 1, asynchronous, active-low.
- flush, input, 1, synchronous kill of all held entries.
- in_valid, input, 1, upstream has an entry.
- in_ready, output, 1, stage can accept. Registered.
- in_data, input, DATA_W, upstream data payload.
- in_ctrl, input, CTRL_W, upstream control payload.
- out_valid, output, 1, out_data/out_ctrl hold a real instruction.
- out_ready, input, 1, downstream accepts.
- out_data, output, DATA_W, head data. Registered.
- out_ctrl, output, CTRL_W, head control. Zero whenever out_valid=0.
- occupancy, output, 2, number of held entries (0..2).

Behaviour:
- Storage:
  - main register: drives the out_* ports.
  - skid register: holds one extra entry.
  - state: EMPTY (0 entries), ONE (main only), TWO (main+skid). occupancy = 0/1/2 respectively.
- Handshake:
  - Input transfer: in_valid & in_ready at the falling edge.
  - Output transfer: out_valid & out_ready at the falling edge.
  - in_ready = (state != TWO). It is a registered flag, never a function of out_ready.
- Transitions (evaluated at the falling edge, no flush):
  - EMPTY, input transfer -> ONE. main <= input.
  - ONE, input and output transfer -> ONE. main <= input.
  - ONE, input only -> TWO. skid <= input.
  - ONE, output only -> EMPTY.
  - TWO, output transfer -> ONE. main <= skid. No input is possible because in_ready=0.
  - Any other combination holds state and all registers.
- Latency and throughput:
  - Input-to-output latency is 1 clock; data is visible on out_* after the first falling edge.
  - Sustained throughput is 1 entry/clock while out_ready=1.
- Ordering: entries leave strictly in arrival order. The skid entry never overtakes main.
- Bubble: when out_valid=0, out_ctrl reads 0, so downstream sees a NOP (no reg/mem write).
- Flush:
  - At the falling edge, flush=1 forces state to EMPTY, out_valid=0, in_ready=1 and out_ctrl=0.
  - out_data becomes 0 if CLR_DATA_ON_FLUSH=1, otherwise it is unchanged.
  - Flush has priority over a simultaneous input transfer: the incoming entry is dropped and the upstream handshake still completes.
  - A simultaneous output transfer still completes: the downstream consumes the head in the same edge.
- Reset:
  - Asserting reset low at any time, including mid-transfer, immediately forces state to EMPTY.
  - While reset is low: out_valid=0, in_ready=0, out_data=0, out_ctrl=0, occupancy=0, skid contents=0.
  - in_ready rises to 1 at the first falling edge after reset deasserts.
- Stall compatibility: tying out_ready to the legacy ~stall and in_valid to 1 reproduces the old enable-gated register, with one-entry slip absorbed by the skid.
- No X propagation: outputs are driven from registers only.

Test Plan:
- Reset then stream:
  - Stimulus: reset low 3 clocks, release; in_valid=1, out_ready=1, in_data=0x10,0x11,0x12.
  - Required: out_data shows 0x10,0x11,0x12 on consecutive edges; occupancy stays 1; in_ready=1 throughout.
- Back-pressure fill:
  - Stimulus: out_ready=0 while sending A=0xAAAA0000 then B=0xBBBB0000.
  - Required: occupancy goes 1 then 2; in_ready=0 after B; out_data holds A.
  - Then raise out_ready for 2 clocks. Required: A then B appear in order; occupancy goes 1 then 0; in_ready returns to 1 after the first drain edge.
- Flush in TWO with simultaneous input:
  - Stimulus: reach TWO; assert flush for 1 clock with in_valid=1.
  - Required: occupancy=0, out_valid=0, out_ctrl=0, out_data=0; the incoming entry does not appear.
- Flush with CLR_DATA_ON_FLUSH=0:
  - Stimulus: same sequence as the previous scenario.
  - Required: out_data retains its last value; out_ctrl=0; out_valid=0.
- Asynchronous reset mid-transfer:
  - Stimulus: pull reset low between clock edges while occupancy=2 and clk is high.
  - Required: all outputs go to reset values immediately, without waiting for an edge.
- Legacy stall emulation:
  - Stimulus: DATA_W=64, CTRL_W=12; in_valid=1; out_ready toggles 1,0,0,1 with an incrementing in_data.
  - Required: no entry is lost or duplicated; the sequence on out_data is monotonic; out_ctrl is nonzero only when out_valid=1.
